// File: rtl/shift_add_mult.sv
// shift_add_mult: iterative shift-add multiply-accumulate.
// product_out = multiplicand_in * multiplier_in + addend_in (unsigned).
// One multiplier bit retires per clock. Latency is fixed at WIDTH cycles
// from the accepting edge to done, followed by one DONE cycle.
//
// state | meaning
// IDLE  | ready=1, waiting for start
// RUN   | WIDTH shift-add iterations in progress
// DONE  | done=1 for one cycle, product_out newly valid

module shift_add_mult #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand_in,
  input  logic [WIDTH-1:0]     multiplier_in,
  input  logic [WIDTH-1:0]     addend_in,
  output logic                 ready,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product_out
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_next;

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      count;
  logic               last_iter;

  // Accumulator value after the current iteration's conditional add.
  assign acc_step  = mplier[0] ? (acc + mcand) : acc;
  assign last_iter = (count == LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_next = RUN;
      end
      RUN: begin
        if (last_iter) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand load, shift-add iterations and result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      count       <= '0;
      product_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc    <= {{WIDTH{1'b0}}, addend_in};
            mcand  <= {{WIDTH{1'b0}}, multiplicand_in};
            mplier <= multiplier_in;
            count  <= '0;
          end
        end
        RUN: begin
          acc    <= acc_step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
          if (last_iter) product_out <= acc_step;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed and random checks for shift_add_mult at WIDTH=32 and WIDTH=8.

module tb_shift_add_mult;

  logic        clk = 1'b0;
  logic        reset;
  logic        start32, start8;
  logic [31:0] a32, b32, c32;
  logic [7:0]  a8, b8, c8;
  logic        ready32, done32, ready8, done8;
  logic [63:0] prod32;
  logic [15:0] prod8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  shift_add_mult #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32),
    .multiplicand_in(a32), .multiplier_in(b32), .addend_in(c32),
    .ready(ready32), .done(done32), .product_out(prod32)
  );

  shift_add_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8),
    .multiplicand_in(a8), .multiplier_in(b8), .addend_in(c8),
    .ready(ready8), .done(done8), .product_out(prod8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one op on the 32-bit unit, check latency and result, return to IDLE.
  task automatic op32(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic [63:0] exp);
    int n;
    a32 = a; b32 = b; c32 = c; start32 = 1'b1;
    tick();
    start32 = 1'b0;
    n = 0;
    while (!done32 && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'd32);
    chk({tag, "_prod"}, prod32, exp);
    tick();
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] c, input logic [15:0] exp);
    int n;
    a8 = a; b8 = b; c8 = c; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'd8);
    chk({tag, "_prod"}, 64'(prod8), 64'(exp));
    tick();
  endtask

  initial begin
    int ready_low, done_cnt, d1, d2;
    logic r33, r34;
    logic [63:0] p1;
    logic [31:0] ra, rb, rc;
    logic [7:0]  sa, sb, sc;
    int lat_bad;

    reset = 1'b1; start32 = 1'b0; start8 = 1'b0;
    a32 = '0; b32 = '0; c32 = '0; a8 = '0; b8 = '0; c8 = '0;

    // Reset held two cycles.
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_ready", 64'(ready32), 64'd1);
      chk("rst_done", 64'(done32), 64'd0);
      chk("rst_prod", prod32, 64'd0);
    end

    // Reset and start on the same edge: reset wins.
    start32 = 1'b1;
    tick();
    reset = 1'b0; start32 = 1'b0;
    tick();
    chk("rst_start_ready", 64'(ready32), 64'd1);

    // Basic reconstruction.
    op32("b0", 32'd3, 32'd3, 32'd1, 64'd10);
    op32("b1", 32'd512, 32'd2, 32'd0, 64'd1024);
    op32("b2", 32'd2, 32'd3, 32'd2, 64'd8);

    // Reset mid-RUN discards the result.
    a32 = 32'd5; b32 = 32'd5; c32 = 32'd0; start32 = 1'b1;
    tick();
    start32 = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_ready", 64'(ready32), 64'd1);
    chk("midrst_done", 64'(done32), 64'd0);
    chk("midrst_prod", prod32, 64'd0);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done32) done_cnt++;
    end
    chk("midrst_nodone", 64'(done_cnt), 64'd0);

    // Extremes.
    op32("x0", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0000);
    op32("x1", 32'd0, 32'h1234, 32'd7, 64'd7);
    op32("x2", 32'h1234, 32'd0, 32'd0, 64'd0);

    // Start during RUN and DONE is ignored.
    a32 = 32'd20; b32 = 32'd5; c32 = 32'd0; start32 = 1'b1;
    tick();
    ready_low = ready32 ? 0 : 1;
    done_cnt = 0;
    a32 = 32'd9; b32 = 32'd9; c32 = 32'd9;
    for (int i = 1; i <= 40; i++) begin
      start32 = (i <= 32) ? 1'b1 : 1'b0;
      tick();
      if (!ready32) ready_low++;
      if (done32) done_cnt++;
    end
    start32 = 1'b0;
    chk("ign_ready_low", 64'(ready_low), 64'd33);
    chk("ign_done_cnt", 64'(done_cnt), 64'd1);
    chk("ign_prod", prod32, 64'd100);

    // Back-to-back with start held high.
    a32 = 32'd10; b32 = 32'd10; c32 = 32'd0; start32 = 1'b1;
    tick();
    d1 = -1; d2 = -1; done_cnt = 0; r33 = 1'b0; r34 = 1'b1; p1 = '0;
    for (int i = 1; i <= 80; i++) begin
      tick();
      if (i == 33) r33 = ready32;
      if (i == 34) r34 = ready32;
      if (done32) begin
        done_cnt++;
        if (d1 < 0) begin
          d1 = i; p1 = prod32;
          a32 = 32'd7; b32 = 32'd4; c32 = 32'd2;
        end else if (d2 < 0) begin
          d2 = i;
          start32 = 1'b0;
        end
      end
    end
    start32 = 1'b0;
    chk("b2b_d1", 64'(d1), 64'd32);
    chk("b2b_p1", p1, 64'd100);
    chk("b2b_r33", 64'(r33), 64'd1);
    chk("b2b_r34", 64'(r34), 64'd0);
    chk("b2b_d2", 64'(d2), 64'd66);
    chk("b2b_p2", prod32, 64'd30);
    chk("b2b_done_cnt", 64'(done_cnt), 64'd2);

    // Narrow unit directed.
    op8("n0", 8'd255, 8'd255, 8'd255, 16'hFF00);
    op8("n1", 8'd12, 8'd13, 8'd5, 16'd161);

    // Random triples against the reference a*b+c.
    lat_bad = 0;
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom; rc = $urandom;
      op32("r32", ra, rb, rc, ({32'd0, ra} * {32'd0, rb}) + {32'd0, rc});
    end
    for (int i = 0; i < 1000; i++) begin
      sa = 8'($urandom_range(0, 255));
      sb = 8'($urandom_range(0, 255));
      sc = 8'($urandom_range(0, 255));
      op8("r8", sa, sb, sc, ({8'd0, sa} * {8'd0, sb}) + {8'd0, sc});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_add_mult.md
# shift_add_mult

Iterative shift-add multiply-accumulate unit computing `product_out = multiplicand_in * multiplier_in + addend_in` on unsigned operands. It is the inverse companion of the sequential divider.

- Feeding it a divider's quotient, divisor and remainder reconstructs the dividend.
- It is used both as a datapath multiplier and as the self-check stage behind the divider.
- It retires one multiplier bit per clock, with a fixed latency and a start/ready/done handshake.

## Interface
- WIDTH, 32, operand width; result is 2*WIDTH bits
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only while ready=1
- multiplicand_in  input  WIDTH  unsigned multiplicand (e.g. quotient)
- multiplier_in  input  WIDTH  unsigned multiplier (e.g. divisor)
- addend_in  input  WIDTH  unsigned addend (e.g. remainder), zero-extended
- ready  output  1  high when idle and able to accept start
- done  output  1  one-cycle pulse: product_out newly valid
- product_out  output  2*WIDTH  result; holds until overwritten by the next completion

## Operation
- States:
  - IDLE: ready=1.
  - RUN: ready=0; WIDTH iterations.
  - DONE: ready=0; done=1.
- Internal registers:
  - acc (2*WIDTH).
  - mcand (2*WIDTH, left-shifting).
  - mplier (WIDTH, right-shifting).
  - count (clog2(WIDTH)+1 bits).
- IDLE with start=1: load acc={0,addend_in}, mcand={0,multiplicand_in}, mplier=multiplier_in, count=0; go to RUN.
- IDLE with start=0: hold; product_out unchanged.
- RUN, each edge:
  - if mplier[0], acc=acc+mcand;
  - mcand=mcand<<1;
  - mplier=mplier>>1;
  - count=count+1.
- On the edge completing iteration WIDTH: product_out takes the final acc value (including that iteration's add); go to DONE.
- DONE: next edge returns to IDLE unconditionally.
- start while RUN or DONE: ignored. No queuing. Inputs need not be held after the accepting edge.
- Arithmetic: unsigned, modulo-free.
  - Maximum (2^W-1)^2 + (2^W-1) = 2^(2W) - 2^W fits in 2*WIDTH bits, so no overflow is possible and no flag is provided.
- Fixed latency: there is no early termination on a zero multiplier.
- Zero operands are legal: multiplier 0 or multiplicand 0 yields addend_in.

## Timing
- Reset values: state=IDLE, ready=1, done=0, product_out=0, acc/mcand/mplier/count=0.
- ready is decoded from state, so it reads 1 while reset is applied.
- Reset mid-RUN or in DONE: the next edge forces IDLE and all reset values. The in-flight result is discarded; done does not pulse.
- start and reset high on the same edge: reset wins; the request is dropped.
- Start accepted at edge T:
  - ready falls after T;
  - iterations occur at edges T+1..T+WIDTH;
  - done=1 and product_out valid after edge T+WIDTH;
  - done=0 and ready=1 after edge T+WIDTH+1.
- Throughput: one operation per WIDTH+2 cycles. start held high continuously is accepted again at the first edge where ready=1 (T+WIDTH+2).
- product_out changes only on the completion edge or on reset.

## Test plan
- Reset: hold reset 2 cycles -> ready=1, done=0, product_out=0 throughout. Pulse reset during RUN, then idle -> no done pulse, product_out=0, ready=1 one cycle after reset edge.
- Basic reconstruction:
  - multiplicand=3, multiplier=3, addend=1 -> product_out=10 with done exactly 32 edges after the start edge.
  - 512,2,0 -> 1024.
  - 2,3,2 -> 8.
- Extremes:
  - 0xFFFFFFFF, 0xFFFFFFFF, 0xFFFFFFFF -> 0xFFFFFFFF_00000000.
  - 0, 0x1234, 7 -> 7.
  - 0x1234, 0, 0 -> 0.
- Ignored start: assert start with 20,5,0; change inputs and pulse start during RUN and DONE -> single done, product_out=100, ready low for exactly 33 cycles.
- Back-to-back: start held high with 10,10,0 then 30/4 inputs switched to 7,4,2 at first done -> results 100 then 30; second start accepted at T+34; done pulses exactly one cycle each.
- Random: 1000 random unsigned triples vs. reference a*b+c at WIDTH=32 and WIDTH=8 -> zero mismatches; latency always WIDTH cycles to done.
